bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous clear, parallel load, and selectable wrap or saturate behaviour at the range limits. Each 4-bit digit field drives one seven-segment digit directly, so no binary-to-BCD conversion is needed downstream. It replaces the plain binary up-counter wherever a display-ready, bidirectional count is required.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; the count range is 0 to 10^DIGITS−1 (legal: 1–8)
- SATURATE, 0, limit behaviour: 0 = wrap around, 1 = hold at the limit

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear to zero
- load  in  1  synchronous parallel load from load_val
- load_val  in  4*DIGITS  BCD load value; digit i occupies bits [4i+3:4i]
- en  in  1  count enable; one step per enabled cycle
- up  in  1  direction: 1 = increment, 0 = decrement
- count  out  4*DIGITS  current count, BCD; digit 0 is the least significant
- at_max  out  1  count equals all nines (decoded from count)
- at_zero  out  1  count equals zero (decoded from count)
- limit  out  1  one-cycle registered pulse: an enabled step hit a range limit

## Operation
- Priority per cycle: clear > load > en > hold.
- clear: count ← 0, limit ← 0.
- load: each digit ← min(load_val digit, 9), so codes A–F load as 9. limit ← 0.
- en with up=1:
  - Increment digit 0. A digit at 9 becomes 0 and carries into the next digit.
  - From all nines: if SATURATE=0, count ← 0; if SATURATE=1, count is held. In both cases limit ← 1.
- en with up=0:
  - Decrement digit 0. A digit at 0 becomes 9 and borrows from the next digit.
  - From zero: if SATURATE=0, count ← all nines; if SATURATE=1, count is held. In both cases limit ← 1.
- No enabled step: count is held and limit ← 0.
- Digits never hold codes A–F under legal operation. If an illegal code is present, the next increment or decrement of that digit treats it as 9.
- up may change on any cycle; it is sampled only when en=1.

## Timing
- Reset values: count = 0, limit = 0, at_zero = 1, at_max = 0.
- Reset asserts asynchronously and takes effect immediately. It is released synchronously to clk, and the first step occurs on the first rising edge with reset low.
- Latency: count and limit update on the rising edge where the command is sampled, so each is visible for the following cycle.
- at_max and at_zero are combinational from registered count, with no input-to-output combinational path.
- limit lasts exactly one cycle per limiting step. Consecutive enabled steps held at a saturated limit produce limit high on every such cycle.
- Reset asserted in the middle of a carry or borrow leaves no partial digit state: all digits reset together.
- Throughput: one step per cycle. The carry chain spans DIGITS stages of combinational logic within one cycle.

## Structure
Shared package (bcd_pkg):
- BCD_W = 4
- BCD_MAX = 4'd9
- digit typedef
- function: clamp a nibble to 9

Sub-module bcd_digit, one per digit, generated DIGITS times:
- Inputs: inc, dec, carry/borrow in, load, load_d.
- Outputs: digit value, carry out, borrow out.
- The top level adds the limit detection, the SATURATE mux, the priority logic, and the limit register.

## Test plan
All scenarios use DIGITS=2.
- Reset: assert reset mid-count at 37 → count=00 immediately with no clock edge, at_zero=1, limit=0.
- Up carry, SATURATE=0: load 08, en=1 up=1 for 3 cycles → 09, 10, 11; limit stays 0.
- Wrap, SATURATE=0: load 98, up for 2 cycles → 99 (at_max=1), then 00 with limit=1 for one cycle. Then down for 1 cycle from 00 → 99 with limit=1.
- Saturate, SATURATE=1: at 99, up for 3 cycles → holds 99 with limit=1 each cycle. At 00, down for 1 cycle → holds 00 with limit=1.
- Priority: clear=load=en=1 with load_val=55 → 00. Then load=en=1 with load_val=5F → 59, no step, limit=0.
- Direction toggle: starting at 10, alternate up=0 and up=1 each enabled cycle → 09, 10, 09, 10.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD counter slice: digit width, the largest
// legal digit code, the digit type, and a nibble clamp used when loading.
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Codes A-F are not decimal digits; they are mapped to 9.
  function automatic bcd_digit_t clamp_to_nine(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD up/down counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   inc, dec    - step direction requests from the top (mutually exclusive)
//   cin         - this digit is allowed to step (carry/borrow from below)
//   load, load_d- synchronous load of load_d (clamped to 9), highest priority
//   q           - current digit value
//   cout        - increment rolls this digit from 9 to 0
//   bout        - decrement rolls this digit from 0 to 9
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       load,
  input  bcd_digit_t load_d,
  output bcd_digit_t q,
  output logic       cout,
  output logic       bout
);

  bcd_digit_t r_q;
  logic       w_top;
  logic       w_zero;

  // An illegal code (A-F) behaves like 9 on the next step.
  assign w_top  = (r_q >= BCD_MAX);
  assign w_zero = (r_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= clamp_to_nine(load_d);
    end else if (cin && inc) begin
      r_q <= w_top ? 4'd0 : (r_q + 4'd1);
    end else if (cin && dec) begin
      if (w_zero)
        r_q <= BCD_MAX;
      else if (r_q > BCD_MAX)
        r_q <= BCD_MAX - 4'd1;
      else
        r_q <= r_q - 4'd1;
    end
  end

  assign q    = r_q;
  assign cout = cin & inc & w_top;
  assign bout = cin & dec & w_zero;

endmodule

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
// Multi-digit BCD up/down counter with synchronous clear, parallel load and
// wrap or saturate behaviour at 0 and 10^DIGITS-1.
// Parameters:
//   DIGITS   - number of BCD digits (1-8)
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   clear      - synchronous clear to zero (highest priority)
//   load       - synchronous load from load_val, each digit clamped to 9
//   load_val   - BCD load value, digit i in bits [4i+3:4i]
//   en, up     - count enable and direction (1 = increment)
//   count      - current BCD count, digit 0 least significant
//   at_max     - count is all nines
//   at_zero    - count is zero
//   limit      - registered one-cycle pulse: an enabled step hit a limit
// ---------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  limit
);

  bcd_digit_t w_q    [DIGITS];
  logic       w_cin  [DIGITS];
  logic       w_cout [DIGITS];
  logic       w_bout [DIGITS];

  logic w_load;
  logic w_step;
  logic w_lim_up;
  logic w_lim_dn;
  logic w_hit;
  logic w_inc;
  logic w_dec;
  logic w_limit_nxt;
  logic r_limit;

  // Clear is realised as a load of zero so the digits need a single load path.
  assign w_load = clear | load;
  assign w_step = en & ~w_load;

  // Range limits are decoded straight from the digits so that the saturate
  // gating does not depend on the ripple chain it controls.
  always_comb begin
    w_lim_up = 1'b1;
    w_lim_dn = 1'b1;
    at_max   = 1'b1;
    at_zero  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_lim_up = w_lim_up & (w_q[i] >= BCD_MAX);
      w_lim_dn = w_lim_dn & (w_q[i] == 4'd0);
      at_max   = at_max   & (w_q[i] == BCD_MAX);
      at_zero  = at_zero  & (w_q[i] == 4'd0);
    end
  end

  assign w_hit = w_step & (up ? w_lim_up : w_lim_dn);
  assign w_inc = w_step &  up & ~(SATURATE & w_hit);
  assign w_dec = w_step & ~up & ~(SATURATE & w_hit);

  assign w_cin[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign w_cin[i] = w_cout[i-1] | w_bout[i-1];
    end
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .inc    (w_inc),
      .dec    (w_dec),
      .cin    (w_cin[i]),
      .load   (w_load),
      .load_d (clear ? 4'd0 : load_val[4*i +: 4]),
      .q      (w_q[i]),
      .cout   (w_cout[i]),
      .bout   (w_bout[i])
    );
    assign count[4*i +: 4] = w_q[i];
  end

  // When wrapping, the carry/borrow out of the top digit marks the limit;
  // when saturating, the stepping is gated off so the decoded hit is used.
  assign w_limit_nxt = SATURATE ? w_hit
                                : (w_cout[DIGITS-1] | w_bout[DIGITS-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_limit <= 1'b0;
    else
      r_limit <= w_limit_nxt;
  end

  assign limit = r_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up;

  logic [7:0] cnt_w, cnt_s;
  logic       max_w, zero_w, lim_w;
  logic       max_s, zero_s, lim_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer count per instance (0 = wrap, 1 = saturate).
  int mv [2];
  bit ml [2];

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_w), .at_max(max_w), .at_zero(zero_w),
    .limit(lim_w)
  );

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_s), .at_max(max_s), .at_zero(zero_s),
    .limit(lim_s)
  );

  always #5 clk = ~clk;

  function automatic int load_value(input logic [7:0] lv);
    int t, o;
    t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return t * 10 + o;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Drive one command for one clock, advance the model, sample after the edge.
  task automatic apply(input bit c, input bit l, input logic [7:0] lv,
                       input bit e, input bit u);
    clear = c; load = l; load_val = lv; en = e; up = u;
    for (int s = 0; s < 2; s++) begin
      if (c) begin
        mv[s] = 0; ml[s] = 1'b0;
      end else if (l) begin
        mv[s] = load_value(lv); ml[s] = 1'b0;
      end else if (e && u) begin
        if (mv[s] == 99) begin
          ml[s] = 1'b1; mv[s] = (s == 1) ? 99 : 0;
        end else begin
          ml[s] = 1'b0; mv[s] = mv[s] + 1;
        end
      end else if (e) begin
        if (mv[s] == 0) begin
          ml[s] = 1'b1; mv[s] = (s == 1) ? 0 : 99;
        end else begin
          ml[s] = 1'b0; mv[s] = mv[s] - 1;
        end
      end else begin
        ml[s] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    // Power-on values.
    n_checks++;
    if (cnt_w !== 8'h00 || zero_w !== 1'b1 || max_w !== 1'b0 || lim_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_wrap: count=%h z=%b m=%b l=%b want 00 1 0 0", cnt_w, zero_w, max_w, lim_w);
    end
    n_checks++;
    if (cnt_s !== 8'h00 || zero_s !== 1'b1 || max_s !== 1'b0 || lim_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init_sat: count=%h z=%b m=%b l=%b want 00 1 0 0", cnt_s, zero_s, max_s, lim_s);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mv[0] = 0; mv[1] = 0; ml[0] = 1'b0; ml[1] = 1'b0;
    // Count to 37, then reset asynchronously between edges.
    apply(1'b0, 1'b1, 8'h36, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (cnt_w !== 8'h37) begin
      n_fail++;
      $display("FAIL reset_precount: count=%h want 37", cnt_w);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (cnt_w !== 8'h00 || zero_w !== 1'b1 || lim_w !== 1'b0 || max_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_wrap: count=%h z=%b l=%b m=%b want 00 1 0 0", cnt_w, zero_w, lim_w, max_w);
    end
    n_checks++;
    if (cnt_s !== 8'h00 || zero_s !== 1'b1 || lim_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_sat: count=%h z=%b l=%b want 00 1 0", cnt_s, zero_s, lim_s);
    end
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b0;
    mv[0] = 0; mv[1] = 0; ml[0] = 1'b0; ml[1] = 1'b0;
  endtask

  task automatic test_up_carry;
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h09; exp_seq[1] = 8'h10; exp_seq[2] = 8'h11;
    apply(1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++;
      if (cnt_w !== exp_seq[i] || lim_w !== 1'b0) begin
        n_fail++;
        $display("FAIL up_carry[%0d]: count=%h limit=%b want %h 0", i, cnt_w, lim_w, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap;
    apply(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (cnt_w !== 8'h99 || max_w !== 1'b1 || lim_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reach_max: count=%h at_max=%b limit=%b want 99 1 0", cnt_w, max_w, lim_w);
    end
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (cnt_w !== 8'h00 || lim_w !== 1'b1 || zero_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_up: count=%h limit=%b at_zero=%b want 00 1 1", cnt_w, lim_w, zero_w);
    end
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (cnt_w !== 8'h99 || lim_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: count=%h limit=%b want 99 1", cnt_w, lim_w);
    end
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (cnt_w !== 8'h99 || lim_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_limit_pulse: count=%h limit=%b want 99 0", cnt_w, lim_w);
    end
  endtask

  task automatic test_saturate;
    apply(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++;
      if (cnt_s !== 8'h99 || lim_s !== 1'b1 || max_s !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: count=%h limit=%b at_max=%b want 99 1 1", i, cnt_s, lim_s, max_s);
      end
    end
    apply(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (cnt_s !== 8'h00 || lim_s !== 1'b1 || zero_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_down: count=%h limit=%b at_zero=%b want 00 1 1", cnt_s, lim_s, zero_s);
    end
  endtask

  task automatic test_priority;
    apply(1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    n_checks++;
    if (cnt_w !== 8'h00 || cnt_s !== 8'h00 || lim_w !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_clear: count=%h/%h limit=%b want 00/00 0", cnt_w, cnt_s, lim_w);
    end
    apply(1'b0, 1'b1, 8'h5F, 1'b1, 1'b1);
    n_checks++;
    if (cnt_w !== 8'h59 || cnt_s !== 8'h59 || lim_w !== 1'b0 || lim_s !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load_clamp: count=%h/%h limit=%b/%b want 59/59 0/0", cnt_w, cnt_s, lim_w, lim_s);
    end
  endtask

  task automatic test_direction;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h09; exp_seq[1] = 8'h10; exp_seq[2] = 8'h09; exp_seq[3] = 8'h10;
    apply(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1, (i % 2) == 1);
      n_checks++;
      if (cnt_w !== exp_seq[i] || cnt_s !== exp_seq[i] || lim_w !== 1'b0) begin
        n_fail++;
        $display("FAIL direction[%0d]: count=%h/%h limit=%b want %h 0", i, cnt_w, cnt_s, lim_w, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random;
    bit c, l, e, u;
    logic [7:0] lv;
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 1) == 1);
      lv = 8'($urandom);
      // Bias loads toward the range limits.
      if ($urandom_range(0, 1) == 1) lv = ($urandom_range(0, 1) == 1) ? 8'h98 : 8'h01;
      apply(c, l, lv, e, u);
      n_checks++;
      if (cnt_w !== to_bcd(mv[0]) || lim_w !== ml[0]) begin
        n_fail++;
        $display("FAIL rand_wrap[%0d]: count=%h limit=%b want %h %b", n, cnt_w, lim_w, to_bcd(mv[0]), ml[0]);
      end
      n_checks++;
      if (cnt_s !== to_bcd(mv[1]) || lim_s !== ml[1]) begin
        n_fail++;
        $display("FAIL rand_sat[%0d]: count=%h limit=%b want %h %b", n, cnt_s, lim_s, to_bcd(mv[1]), ml[1]);
      end
      n_checks++;
      if (max_w !== (mv[0] == 99) || zero_w !== (mv[0] == 0) ||
          max_s !== (mv[1] == 99) || zero_s !== (mv[1] == 0)) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: max/zero wrap=%b%b sat=%b%b want %b%b %b%b", n,
                 max_w, zero_w, max_s, zero_s, mv[0] == 99, mv[0] == 0, mv[1] == 99, mv[1] == 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b1;
    #12;
    test_reset;
    test_up_carry;
    test_wrap;
    test_saturate;
    test_priority;
    test_direction;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
